// File: rtl/wifi_reset_sequencer.sv
// Wi-Fi module reset pulse / boot-wait sequencer with an Avalon-MM register interface.
// One START write asserts wifi_rst_n for PULSE_LEN clocks, then waits BOOT_WAIT clocks
// before flagging wifi_ready. MAN_EN gives software direct control of the pin.
// Optional feature macro: WIFI_RST_IRQ_EN (adds irq output and CTRL bit3 IRQ_MASK).
module wifi_reset_sequencer #(
  parameter int unsigned CNT_W         = 26,
  parameter int unsigned PULSE_DEFAULT = 50000,
  parameter int unsigned BOOT_DEFAULT  = 25000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        wifi_rst_n,
  output logic        wifi_ready
`ifdef WIFI_RST_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_BOOT   = 2'd2;
  localparam logic [1:0] S_READY  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pulse_len_q, pulse_len_d;
  logic [CNT_W-1:0] boot_wait_q, boot_wait_d;
  logic             man_en_q, man_en_d;
  logic             man_lvl_q, man_lvl_d;
  logic             irq_pend_q, irq_pend_d;
  logic             wifi_rst_n_q, wifi_rst_n_d;
  logic             wifi_ready_q, wifi_ready_d;
`ifdef WIFI_RST_IRQ_EN
  logic             irq_mask_q, irq_mask_d;
  logic             irq_q, irq_d;
`endif

  logic wr_c, wr_ctrl_c, wr_pulse_c, wr_boot_c, wr_status_c;
  logic start_c, set_pend_c, busy_c;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:CNT_W];

  // Counter reload value: max(v,1) - 1
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  // Bus decode
  always_comb begin
    wr_c        = chipselect & ~write_n;
    wr_ctrl_c   = wr_c && (address == 2'd0);
    wr_pulse_c  = wr_c && (address == 2'd1);
    wr_boot_c   = wr_c && (address == 2'd2);
    wr_status_c = wr_c && (address == 2'd3);
    start_c     = wr_ctrl_c & writedata[0] & ~writedata[1];
  end

  // Next-state, register updates and output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pulse_len_d = pulse_len_q;
    boot_wait_d = boot_wait_q;
    man_en_d    = man_en_q;
    man_lvl_d   = man_lvl_q;
    irq_pend_d  = irq_pend_q;
    set_pend_c  = 1'b0;
`ifdef WIFI_RST_IRQ_EN
    irq_mask_d  = irq_mask_q;
`endif

    if (wr_ctrl_c) begin
      man_en_d  = writedata[1];
      man_lvl_d = writedata[2];
`ifdef WIFI_RST_IRQ_EN
      irq_mask_d = writedata[3];
`endif
    end
    if (wr_pulse_c) pulse_len_d = writedata[CNT_W-1:0];
    if (wr_boot_c) boot_wait_d = writedata[CNT_W-1:0];
    if (wr_status_c && writedata[2]) irq_pend_d = 1'b0;

    case (state_q)
      S_IDLE, S_READY: begin
        if (start_c) begin
          state_d = S_ASSERT;
          cnt_d   = load_val(pulse_len_q);
        end
      end
      S_ASSERT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_BOOT;
          cnt_d   = load_val(boot_wait_q);
        end
      end
      S_BOOT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d    = S_READY;
          set_pend_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Manual override aborts any sequence and suppresses completion
    if (man_en_d) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      set_pend_c = 1'b0;
    end

    // Completion beats a same-cycle clear
    if (set_pend_c) irq_pend_d = 1'b1;

    wifi_rst_n_d = man_en_d ? man_lvl_d : (state_d != S_ASSERT);
    wifi_ready_d = (state_d == S_READY);
`ifdef WIFI_RST_IRQ_EN
    irq_d        = irq_pend_d & irq_mask_d;
`endif
  end

  // State and register flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pulse_len_q  <= CNT_W'(PULSE_DEFAULT);
      boot_wait_q  <= CNT_W'(BOOT_DEFAULT);
      man_en_q     <= 1'b0;
      man_lvl_q    <= 1'b1;
      irq_pend_q   <= 1'b0;
      wifi_rst_n_q <= 1'b1;
      wifi_ready_q <= 1'b0;
`ifdef WIFI_RST_IRQ_EN
      irq_mask_q   <= 1'b0;
      irq_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pulse_len_q  <= pulse_len_d;
      boot_wait_q  <= boot_wait_d;
      man_en_q     <= man_en_d;
      man_lvl_q    <= man_lvl_d;
      irq_pend_q   <= irq_pend_d;
      wifi_rst_n_q <= wifi_rst_n_d;
      wifi_ready_q <= wifi_ready_d;
`ifdef WIFI_RST_IRQ_EN
      irq_mask_q   <= irq_mask_d;
      irq_q        <= irq_d;
`endif
    end
  end

  assign wifi_rst_n = wifi_rst_n_q;
  assign wifi_ready = wifi_ready_q;
`ifdef WIFI_RST_IRQ_EN
  assign irq        = irq_q;
`endif

  // Zero-wait-state read mux
  always_comb begin
    busy_c   = (state_q == S_ASSERT) || (state_q == S_BOOT);
    readdata = '0;
    case (address)
`ifdef WIFI_RST_IRQ_EN
      2'd0: readdata = {28'b0, irq_mask_q, man_lvl_q, man_en_q, 1'b0};
`else
      2'd0: readdata = {29'b0, man_lvl_q, man_en_q, 1'b0};
`endif
      2'd1: readdata = 32'(pulse_len_q);
      2'd2: readdata = 32'(boot_wait_q);
      default: readdata = {29'b0, irq_pend_q, wifi_ready_q, busy_c};
    endcase
  end

endmodule

// File: doc/wifi_reset_sequencer.md
Name: wifi_reset_sequencer

Overview:
Avalon-MM slave that generates the Wi-Fi module's active-low reset pulse and boot-wait sequence in hardware, so software does not need to bit-bang a PIO with software delays. One register write starts the sequence: assert the reset line for a programmable number of clocks, release it, wait a programmable boot time, then flag the module ready. A manual override gives software direct control of the pin for debug and bring-up. Sits on the Nios system interconnect; the wifi_rst_n pin drives the module's RST input.

Parameters:
CNT_W, 26, width of the pulse and boot-wait counters and their registers
PULSE_DEFAULT, 50000, PULSE_LEN reset value in clk cycles (1 ms at 50 MHz)
BOOT_DEFAULT, 25000000, BOOT_WAIT reset value in clk cycles (0.5 s at 50 MHz)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational, zero wait states
wifi_rst_n  out  1  reset pin to the Wi-Fi module, active low
wifi_ready  out  1  high once the boot wait has completed
irq  out  1  level interrupt; present only with WIFI_RST_IRQ_EN

Behaviour:
- Clock and reset: reset reset_n, asynchronous, active-low; clock clk. All registers use posedge clk / negedge reset_n.
- Write strobe: wr = chipselect & ~write_n. Reads have no side effects.
- Register map:
  - addr 0 CTRL. Write bit0 START (self-clearing, always reads 0), bit1 MAN_EN, bit2 MAN_LVL. Read returns {29'b0, MAN_LVL, MAN_EN, 1'b0}.
  - addr 1 PULSE_LEN[CNT_W-1:0]. Reads back the value; upper bits read 0.
  - addr 2 BOOT_WAIT[CNT_W-1:0]. Reads back the value; upper bits read 0.
  - addr 3 STATUS. Read {29'b0, irq_pend, wifi_ready, busy}. Writing 1 to bit2 clears irq_pend.
- Reset values:
  - state IDLE, wifi_rst_n=1, wifi_ready=0, irq=0.
  - MAN_EN=0, MAN_LVL=1.
  - PULSE_LEN=PULSE_DEFAULT, BOOT_WAIT=BOOT_DEFAULT.
  - counter=0.
- States:
  - IDLE: wifi_rst_n=1, ready=0, busy=0.
  - ASSERT: wifi_rst_n=0, busy=1.
  - BOOT: wifi_rst_n=1, busy=1.
  - READY: wifi_rst_n=1, ready=1, busy=0.
- Transitions:
  - IDLE or READY, START written with MAN_EN=0 → ASSERT. Load cnt = max(PULSE_LEN,1) - 1; ready drops the same edge.
  - ASSERT: cnt≠0 → decrement. cnt==0 → BOOT, load cnt = max(BOOT_WAIT,1) - 1.
  - BOOT: cnt≠0 → decrement. cnt==0 → READY, set irq_pend.
- Timing: START written at edge T gives wifi_rst_n low on cycles T+1 .. T+P, where P = max(PULSE_LEN,1). wifi_ready rises at edge T+P+B, where B = max(BOOT_WAIT,1).
- START while in ASSERT or BOOT is ignored; the sequence is not restarted.
- PULSE_LEN/BOOT_WAIT writes during a sequence take effect on the next load only.
- Manual override: MAN_EN=1 forces wifi_rst_n=MAN_LVL and state to IDLE (aborts any sequence; ready=0; no irq) and blocks START. Clearing MAN_EN leaves state in IDLE.
- Same-cycle CTRL write with START=1 and MAN_EN=1: MAN_EN wins; no sequence starts.
- Simultaneous irq_pend set (BOOT→READY) and clear write: set wins.
- reset_n asserted mid-sequence returns immediately to reset values; wifi_rst_n goes high asynchronously.

Optional Feature:
WIFI_RST_IRQ_EN.
- Defined: irq port exists and irq = irq_pend & IRQ_MASK. IRQ_MASK is CTRL bit3, reset 0, readable.
- Undefined: no irq port, no IRQ_MASK. irq_pend still sets and clears and is visible in STATUS bit2. CTRL bit3 reads 0.

Test Plan:
1. After reset, no writes → wifi_rst_n=1, wifi_ready=0; reads return addr1=50000, addr2=25000000, STATUS=0.
2. PULSE_LEN=3, BOOT_WAIT=5, START at edge T → wifi_rst_n low on cycles T+1..T+3; wifi_ready=1 from edge T+8; STATUS reads 0b110.
3. PULSE_LEN=0, BOOT_WAIT=0, START → exactly 1 low cycle; ready 2 cycles after the write.
4. START during BOOT (PULSE=3, BOOT=5) → timing identical to scenario 2; START in READY restarts the sequence and ready drops.
5. MAN_EN=1, MAN_LVL=0 written mid-ASSERT → wifi_rst_n=0, state IDLE, busy=0, irq_pend stays 0; START with MAN_EN=1 has no effect.
6. With WIFI_RST_IRQ_EN and IRQ_MASK=1, run the sequence → irq=1 at READY; STATUS write 0x4 → irq=0. Assert reset_n mid-BOOT → all outputs return to reset values.
